// File: rtl/db9md_pad_scanner.sv
// db9md_pad_scanner: polls two Mega Drive / Atari pads through one SNAC DB9
// port, alternating ports each scan and latching active-high button words.
module db9md_pad_scanner #(
    parameter int STEP_CYCLES = 320,
    parameter int IDLE_CYCLES = 80000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  joy_in,
    output logic        joy_mdsel,
    output logic        joy_split,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2
);
    localparam int MAXC = (IDLE_CYCLES > STEP_CYCLES) ? IDLE_CYCLES : STEP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] STEP_LD = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3,
        ST_S4, ST_S5, ST_S6, ST_S7, ST_LATCH
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          last;
    logic [5:0]    sync1, sync2;
    logic [5:0]    press;
    logic [5:0]    s0;
    logic [1:0]    s1;
    logic [3:0]    s6;
    logic          md, six;
    logic [15:0]   word;

    assign press = ~sync2;
    assign last  = (cnt == '0);

    always_comb begin
        state_nx = state;
        cnt_nx   = last ? cnt : cnt - CW'(1);
        case (state)
            ST_IDLE: if (last) begin
                state_nx = ST_S0;
                cnt_nx   = STEP_LD;
            end
            ST_S7: if (last) begin
                state_nx = ST_LATCH;
                cnt_nx   = '0;
            end
            ST_LATCH: begin
                state_nx = ST_IDLE;
                cnt_nx   = IDLE_LD;
            end
            default: if (last) begin
                state_nx = state_t'(state + 4'd1);
                cnt_nx   = STEP_LD;
            end
        endcase
    end

    // Extended bits only count when the pad proved it is a 6-button type
    always_comb begin
        word = 16'h0000;
        word[5:0] = {s0[5], s0[4], s0[0], s0[1], s0[2], s0[3]};
        if (md)
            word[7:6] = s1;
        if (md && six)
            word[11:8] = {s6[0], s6[1], s6[2], s6[3]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= '1;
            sync2     <= '1;
            state     <= ST_IDLE;
            cnt       <= IDLE_LD;
            s0        <= '0;
            s1        <= '0;
            s6        <= '0;
            md        <= 1'b0;
            six       <= 1'b0;
            joy_mdsel <= 1'b1;
            joy_split <= 1'b0;
            joystick1 <= '0;
            joystick2 <= '0;
        end else begin
            sync1     <= joy_in;
            sync2     <= sync1;
            state     <= state_nx;
            cnt       <= cnt_nx;
            joy_mdsel <= !(state inside {ST_S1, ST_S3, ST_S5, ST_S7});
            if (last) begin
                case (state)
                    ST_S0: s0 <= press;
                    ST_S1: begin
                        s1 <= press[5:4];
                        md <= press[2] & press[3];
                    end
                    ST_S5: six <= &press[3:0];
                    ST_S6: s6 <= press[3:0];
                    default: ;
                endcase
            end
            if (state == ST_LATCH) begin
                if (joy_split)
                    joystick2 <= word;
                else
                    joystick1 <= word;
                joy_split <= ~joy_split;
            end
        end
    end
endmodule

// File: tb/tb_db9md_pad_scanner.sv
// tb_db9md_pad_scanner: behavioural pad models on both ports; expected
// words are queued per scan and compared when the port is latched.
module tb_db9md_pad_scanner;
    localparam int STEP = 8;
    localparam int IDLE = 40;
    localparam int SCAN = IDLE + 8 * STEP + 1;
    localparam int TMO  = 30;

    typedef enum int {P_NONE, P_2B, P_3B, P_6B} pad_t;
    typedef struct {
        logic        port;
        logic [15:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  joy_in;
    logic        joy_mdsel;
    logic        joy_split;
    logic [15:0] joystick1;
    logic [15:0] joystick2;

    int          tests = 0;
    int          fails = 0;
    pad_t        ptype [2];
    logic [11:0] pbtn [2];
    logic [15:0] hold [2];
    exp_t        q [$];

    int          ph = 0;
    int          hi = 0;
    logic        msel_q = 1'b1;
    int          p;
    int          idx;
    pad_t        t;
    logic [11:0] b;
    logic [5:0]  press;

    always #5 clk = ~clk;

    db9md_pad_scanner #(
        .STEP_CYCLES(STEP),
        .IDLE_CYCLES(IDLE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .joy_in(joy_in),
        .joy_mdsel(joy_mdsel),
        .joy_split(joy_split),
        .joystick1(joystick1),
        .joystick2(joystick2)
    );

    // Pad select counter, cleared after a long select-high period
    always @(negedge clk) begin
        msel_q <= joy_mdsel;
        if (joy_mdsel !== msel_q) begin
            ph <= ph + 1;
            hi <= 0;
        end else if (joy_mdsel) begin
            if (hi >= TMO)
                ph <= 0;
            else
                hi <= hi + 1;
        end
    end

    always_comb begin
        press = 6'd0;
        idx   = (joy_split === 1'b1) ? 1 : 0;
        t     = ptype[idx];
        b     = pbtn[idx];
        p     = ph % 8;
        case (t)
            P_2B: press = {b[5], b[4], b[0], b[1], b[2], b[3]};
            P_3B, P_6B: begin
                if (t == P_6B && p == 5)
                    press = {b[7], b[6], 4'b1111};
                else if (t == P_6B && p == 6)
                    press = {b[5], b[4], b[8], b[9], b[10], b[11]};
                else if (t == P_6B && p == 7)
                    press = {b[7], b[6], 4'b0000};
                else if (p % 2 == 1)
                    press = {b[7], b[6], 2'b11, b[2], b[3]};
                else
                    press = {b[5], b[4], b[0], b[1], b[2], b[3]};
            end
            default: press = 6'd0;
        endcase
    end

    assign joy_in = ~press;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input pad_t pt, input logic [11:0] pb);
        case (pt)
            P_2B: return {10'd0, pb[5:0]};
            P_3B: return {8'd0, pb[7:0]};
            P_6B: return {4'd0, pb};
            default: return 16'd0;
        endcase
    endfunction

    task automatic push_exp(input logic port);
        exp_t e;
        e.port = port;
        e.word = exp_word(ptype[port], pbtn[port]);
        q.push_back(e);
    endtask

    task automatic wait_toggle();
        logic s;
        int   n;
        s = joy_split;
        n = 0;
        while (joy_split === s && n < 2 * SCAN) begin
            @(negedge clk);
            n++;
        end
        check("split_toggle_seen", 32'(joy_split !== s), 32'd1);
    endtask

    task automatic scan(input logic port);
        check("scan_port", 32'(joy_split), 32'(port));
        push_exp(port);
        wait_toggle();
    endtask

    task automatic count_fall();
        int n;
        n = 0;
        while (joy_mdsel !== 1'b0 && n < 2 * SCAN) begin
            @(negedge clk);
            n++;
        end
        check("first_mdsel_fall", n, IDLE + STEP + 1);
    endtask

    // Monitor: select pulse shape, scan period and latched words
    initial begin : monitor
        logic prev_split;
        logic prev_mdsel;
        int   low_run;
        int   pulses;
        int   cyc;
        int   last_tog;
        exp_t e;
        prev_split = 1'b0;
        prev_mdsel = 1'b1;
        low_run = 0;
        pulses = 0;
        cyc = 0;
        last_tog = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                low_run = 0;
                pulses = 0;
                last_tog = -1;
            end else begin
                if (joy_mdsel === 1'b0) begin
                    low_run++;
                end else if (prev_mdsel === 1'b0) begin
                    check("mdsel_low_width", low_run, STEP);
                    pulses++;
                    low_run = 0;
                end
                if (joy_split !== prev_split) begin
                    check("pulses_per_scan", pulses, 4);
                    pulses = 0;
                    if (last_tog >= 0)
                        check("split_period", cyc - last_tog, SCAN);
                    last_tog = cyc;
                    if (q.size() == 0) begin
                        check("scoreboard_has_entry", 32'd0, 32'd1);
                    end else begin
                        e = q.pop_front();
                        check("latched_port", 32'(prev_split), 32'(e.port));
                        if (prev_split === 1'b0) begin
                            check("joystick1", 32'(joystick1), 32'(e.word));
                            check("joystick2_hold", 32'(joystick2), 32'(hold[1]));
                            hold[0] = e.word;
                        end else begin
                            check("joystick2", 32'(joystick2), 32'(e.word));
                            check("joystick1_hold", 32'(joystick1), 32'(hold[0]));
                            hold[1] = e.word;
                        end
                    end
                end
            end
            prev_mdsel = joy_mdsel;
            prev_split = joy_split;
        end
    end

    initial begin
        hold[0] = 16'h0;
        hold[1] = 16'h0;
        ptype[0] = P_6B;
        pbtn[0] = 12'h8C0;
        ptype[1] = P_NONE;
        pbtn[1] = 12'h000;
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mdsel", 32'(joy_mdsel), 32'd1);
        check("rst_split", 32'(joy_split), 32'd0);
        check("rst_joy1", 32'(joystick1), 32'd0);
        check("rst_joy2", 32'(joystick2), 32'd0);

        reset_n = 1'b1;
        push_exp(1'b0);
        count_fall();
        wait_toggle();

        ptype[1] = P_3B;
        pbtn[1] = 12'h039;
        push_exp(1'b1);
        repeat (20) @(negedge clk);
        ptype[0] = P_2B;
        pbtn[0] = 12'h022;
        wait_toggle();

        scan(1'b0);
        ptype[1] = P_6B;
        pbtn[1] = 12'hCC0;
        scan(1'b1);
        pbtn[0] = 12'h012;
        scan(1'b0);
        ptype[1] = P_NONE;
        scan(1'b1);
        ptype[0] = P_NONE;
        scan(1'b0);
        ptype[1] = P_3B;
        pbtn[1] = 12'h0F3;
        scan(1'b1);
        ptype[0] = P_6B;
        pbtn[0] = 12'h312;
        scan(1'b0);
        ptype[1] = P_6B;
        pbtn[1] = 12'hFFF;
        scan(1'b1);

        push_exp(1'b0);
        repeat (IDLE + 3 * STEP + 4) @(negedge clk);
        check("mid_s3_mdsel", 32'(joy_mdsel), 32'd0);
        reset_n = 1'b0;
        #1;
        check("async_rst_mdsel", 32'(joy_mdsel), 32'd1);
        check("async_rst_split", 32'(joy_split), 32'd0);
        check("async_rst_joy1", 32'(joystick1), 32'd0);
        check("async_rst_joy2", 32'(joystick2), 32'd0);
        q.delete();
        hold[0] = 16'h0;
        hold[1] = 16'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        push_exp(1'b0);
        count_fall();
        wait_toggle();
        scan(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
